imem_loader_ctrl: RTL and testbench

Load controller for the byte-addressed instruction memory of the RISC-V core. It accepts a program as a valid/ready byte stream and writes it little-endian into consecutive IMEM byte cells from address 0. It holds the core in stall until a complete, word-aligned image is resident, then flags fetches that fall outside the loaded image. It sits between the external program source, the IMEM write port and the core's fetch stage.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_ctrl.sv | 84 ++++++++
 tb/tb_imem_loader_ctrl.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Handshake, IMEM write port and fetch-side signals of the IMEM load controller.
// master: program source / core side. slave: the load controller.
interface imem_loader_if;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [31:0] if_pc;
    logic        core_stall;
    logic        fetch_oob;
    logic        load_done;
    logic        load_err;
    logic [7:0]  byte_count;

    modport master (
        output start, ld_valid, ld_byte, ld_last, if_pc,
        input  ld_ready, mem_we, mem_waddr, mem_wdata,
               core_stall, fetch_oob, load_done, load_err, byte_count
    );

    modport slave (
        input  start, ld_valid, ld_byte, ld_last, if_pc,
        output ld_ready, mem_we, mem_waddr, mem_wdata,
               core_stall, fetch_oob, load_done, load_err, byte_count
    );
endinterface

// File: rtl/imem_loader_ctrl.sv
// IMEM load controller: streams a program image byte by byte into IMEM
// (little-endian, from address 0), stalls the core until a complete
// word-aligned image is resident, then flags out-of-image fetches.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, nothing loaded; waits for start
// LOAD  | accepting bytes, each written one cycle after acceptance
// DONE  | aligned image resident; core released once last write retires
// ERR   | misaligned final byte or overflow; partial image left in IMEM
module imem_loader_ctrl #(
    parameter int DEPTH = 40
) (
    input logic         clk,
    input logic         rst_n,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t     state;
    logic [7:0] count;
    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;

    // State, byte counter and the one-cycle-delayed IMEM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= 8'd0;
            we_q   <= 1'b0;
            addr_q <= 8'd0;
            data_q <= 8'd0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state <= LOAD;
                        count <= 8'd0;
                    end
                end
                LOAD: begin
                    if (bus.ld_valid) begin
                        if (count == DEPTH_B) begin
                            // Memory full: the byte is swallowed, not written.
                            state <= ERR;
                        end else begin
                            we_q   <= 1'b1;
                            addr_q <= count;
                            data_q <= bus.ld_byte;
                            count  <= count + 8'd1;
                            if (bus.ld_last) begin
                                // count+1 is a multiple of 4 exactly when count ends in 2'b11.
                                state <= (count[1:0] == 2'b11) ? DONE : ERR;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and fetch-bound outputs decoded from the registered state.
    always_comb begin
        bus.ld_ready   = (state == LOAD);
        bus.load_done  = (state == DONE);
        bus.load_err   = (state == ERR);
        // Keep the core stalled while the final write is still in flight.
        bus.core_stall = !((state == DONE) && !we_q);
        // 33-bit sum so a fetch near the top of the address space cannot wrap.
        bus.fetch_oob  = (state == DONE) &&
                         (({1'b0, bus.if_pc} + 33'd3) >= {25'd0, count});
        bus.byte_count = count;
        bus.mem_we     = we_q;
        bus.mem_waddr  = {24'd0, addr_q};
        bus.mem_wdata  = data_q;
    end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Self-checking bench for imem_loader_ctrl: scenario tasks with a
// transaction-level load model driven from recorded acceptances.
module tb_imem_loader_ctrl;

    localparam int DEPTH  = 40;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if bus ();

    imem_loader_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;

    int          wr_stamp[$];
    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    bit          stall_at[int];

    int          acc_stamp[$];
    logic [7:0]  acc_byte[$];
    bit          acc_last[$];

    int          exp_stamp[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          exp_state;
    int          exp_cnt;

    logic [7:0]  img[0:63];

    // Negedge monitor: cycle stamp, stall history and every IMEM write.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        stall_at[ncyc] = bus.core_stall;
        if (bus.mem_we) begin
            wr_stamp.push_back(ncyc);
            wr_addr.push_back(bus.mem_waddr);
            wr_data.push_back(bus.mem_wdata);
        end
    end

    // Reference: replay accepted bytes against the load rules.
    function automatic void model_load();
        int cnt = 0;
        int st = M_LOAD;
        exp_stamp.delete();
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < acc_stamp.size(); k++) begin
            if (st != M_LOAD) break;
            if (cnt == DEPTH) begin
                st = M_ERR;
            end else begin
                exp_stamp.push_back(acc_stamp[k] + 1);
                exp_addr.push_back(32'(cnt));
                exp_data.push_back(acc_byte[k]);
                cnt++;
                if (acc_last[k]) st = (cnt % 4 == 0) ? M_DONE : M_ERR;
            end
        end
        exp_state = st;
        exp_cnt = cnt;
    endfunction

    task automatic clear_capture();
        wr_stamp.delete();
        wr_addr.delete();
        wr_data.delete();
        acc_stamp.delete();
        acc_byte.delete();
        acc_last.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // gap_mode: 0 = valid held high, 1 = valid every other cycle, 2 = random.
    task automatic drive_load(input int n, input int last_idx, input int gap_mode);
        int i = 0;
        int budget = 0;
        bit v;
        bit stopped = 1'b0;
        while (i < n && budget < 400) begin
            @(negedge clk);
            budget++;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.ld_valid = v;
            bus.ld_byte  = img[i];
            bus.ld_last  = (i == last_idx);
            #1;
            if (v && bus.ld_ready) begin
                acc_stamp.push_back(ncyc);
                acc_byte.push_back(img[i]);
                acc_last.push_back(i == last_idx);
                i++;
            end else if (i > 0 && !bus.ld_ready) begin
                stopped = 1'b1;
                break;
            end
        end
        if (!stopped && i < n) begin
            vectors++;
            miscompares++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, n);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_byte = 8'h00;
        bus.ld_last = 1'b0;
        bus.if_pc = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b0 || bus.core_stall !== 1'b1 || bus.load_done !== 1'b0 ||
            bus.load_err !== 1'b0 || bus.fetch_oob !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.mem_waddr !== 32'h0 || bus.mem_wdata !== 8'h00 || bus.byte_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b stall=%b done=%b err=%b oob=%b we=%b a=%h d=%h cnt=%0d, required 0 1 0 0 0 0 0 0 0",
                     bus.ld_ready, bus.core_stall, bus.load_done, bus.load_err, bus.fetch_oob,
                     bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.byte_count);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_beats_start: ld_ready got %b required 0", bus.ld_ready);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        for (int i = 0; i < 12; i++) img[i] = 8'(i);
        clear_capture();
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_on_start: got %b required 0", bus.ld_ready);
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b1 || bus.byte_count !== 8'd0) begin
            miscompares++;
            $display("FAIL b2b_ready_after_start: got rdy=%b cnt=%0d required 1 0", bus.ld_ready, bus.byte_count);
        end
        drive_load(12, 11, 0);
        model_load();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (wr_stamp.size() != exp_stamp.size()) begin
            miscompares++;
            $display("FAIL b2b_write_count: got %0d required %0d", wr_stamp.size(), exp_stamp.size());
        end
        for (int k = 0; k < exp_stamp.size() && k < wr_stamp.size(); k++) begin
            vectors++;
            if (wr_stamp[k] != exp_stamp[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: got t=%0d a=%h d=%h required t=%0d a=%h d=%h",
                         k, wr_stamp[k], wr_addr[k], wr_data[k], exp_stamp[k], exp_addr[k], exp_data[k]);
            end
        end
        vectors++;
        if (bus.load_done !== (exp_state == M_DONE) || bus.byte_count !== 8'(exp_cnt)) begin
            miscompares++;
            $display("FAIL b2b_final: got done=%b cnt=%0d required done=%b cnt=%0d",
                     bus.load_done, bus.byte_count, exp_state == M_DONE, exp_cnt);
        end
        s = acc_stamp[acc_stamp.size() - 1];
        vectors++;
        if (stall_at[s + 1] !== 1'b1 || stall_at[s + 2] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stall_release: got stall@+1=%b stall@+2=%b required 1 0",
                     stall_at[s + 1], stall_at[s + 2]);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 12; i++) img[i] = 8'(i);
        clear_capture();
        pulse_start();
        drive_load(12, 11, 1);
        model_load();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (wr_stamp.size() != exp_stamp.size()) begin
            miscompares++;
            $display("FAIL gap_write_count: got %0d required %0d", wr_stamp.size(), exp_stamp.size());
        end
        for (int k = 0; k < exp_stamp.size() && k < wr_stamp.size(); k++) begin
            vectors++;
            if (wr_stamp[k] != exp_stamp[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL gap_write[%0d]: got t=%0d a=%h d=%h required t=%0d a=%h d=%h",
                         k, wr_stamp[k], wr_addr[k], wr_data[k], exp_stamp[k], exp_addr[k], exp_data[k]);
            end
        end
        vectors++;
        if (bus.load_done !== 1'b1 || bus.core_stall !== 1'b0 || bus.byte_count !== 8'd12) begin
            miscompares++;
            $display("FAIL gap_final: got done=%b stall=%b cnt=%0d required 1 0 12",
                     bus.load_done, bus.core_stall, bus.byte_count);
        end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 6; i++) img[i] = 8'($urandom);
        clear_capture();
        pulse_start();
        drive_load(6, 5, 0);
        model_load();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (wr_stamp.size() != exp_stamp.size()) begin
            miscompares++;
            $display("FAIL mis_write_count: got %0d required %0d", wr_stamp.size(), exp_stamp.size());
        end
        for (int k = 0; k < exp_stamp.size() && k < wr_stamp.size(); k++) begin
            vectors++;
            if (wr_stamp[k] != exp_stamp[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL mis_write[%0d]: got t=%0d a=%h d=%h required t=%0d a=%h d=%h",
                         k, wr_stamp[k], wr_addr[k], wr_data[k], exp_stamp[k], exp_addr[k], exp_data[k]);
            end
        end
        vectors++;
        if (bus.load_err !== (exp_state == M_ERR) || bus.core_stall !== 1'b1 ||
            bus.load_done !== 1'b0 || bus.byte_count !== 8'(exp_cnt)) begin
            miscompares++;
            $display("FAIL mis_final: got err=%b stall=%b done=%b cnt=%0d required err=%b stall=1 done=0 cnt=%0d",
                     bus.load_err, bus.core_stall, bus.load_done, bus.byte_count, exp_state == M_ERR, exp_cnt);
        end
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        vectors++;
        if (bus.load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_err_before_edge: got %b required 1", bus.load_err);
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        vectors++;
        if (bus.load_err !== 1'b0 || bus.ld_ready !== 1'b1 || bus.byte_count !== 8'd0) begin
            miscompares++;
            $display("FAIL mis_restart: got err=%b rdy=%b cnt=%0d required 0 1 0",
                     bus.load_err, bus.ld_ready, bus.byte_count);
        end
        clear_capture();
        drive_load(4, 3, 0);
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.load_done !== 1'b1 || bus.byte_count !== 8'd4 || wr_stamp.size() != 4) begin
            miscompares++;
            $display("FAIL mis_reload: got done=%b cnt=%0d writes=%0d required 1 4 4",
                     bus.load_done, bus.byte_count, wr_stamp.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 41; i++) img[i] = 8'($urandom);
        clear_capture();
        pulse_start();
        drive_load(41, -1, 0);
        model_load();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (wr_stamp.size() != exp_stamp.size() || acc_stamp.size() != 41) begin
            miscompares++;
            $display("FAIL ovf_write_count: got writes=%0d accepts=%0d required %0d 41",
                     wr_stamp.size(), acc_stamp.size(), exp_stamp.size());
        end
        for (int k = 0; k < exp_stamp.size() && k < wr_stamp.size(); k++) begin
            vectors++;
            if (wr_stamp[k] != exp_stamp[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL ovf_write[%0d]: got t=%0d a=%h d=%h required t=%0d a=%h d=%h",
                         k, wr_stamp[k], wr_addr[k], wr_data[k], exp_stamp[k], exp_addr[k], exp_data[k]);
            end
        end
        vectors++;
        if (bus.load_err !== (exp_state == M_ERR) || bus.byte_count !== 8'(exp_cnt) || bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_final: got err=%b cnt=%0d rdy=%b required err=%b cnt=%0d rdy=0",
                     bus.load_err, bus.byte_count, bus.ld_ready, exp_state == M_ERR, exp_cnt);
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        clear_capture();
        pulse_start();
        drive_load(5, -1, 0);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = img[5];
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b0 || bus.core_stall !== 1'b1 || bus.load_done !== 1'b0 ||
            bus.load_err !== 1'b0 || bus.fetch_oob !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.mem_waddr !== 32'h0 || bus.mem_wdata !== 8'h00 || bus.byte_count !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_values: got rdy=%b stall=%b done=%b err=%b oob=%b we=%b a=%h d=%h cnt=%0d, required 0 1 0 0 0 0 0 0 0",
                     bus.ld_ready, bus.core_stall, bus.load_done, bus.load_err, bus.fetch_oob,
                     bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.byte_count);
        end
        bus.ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_load();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (wr_stamp.size() != 5) begin
            miscompares++;
            $display("FAIL midrst_write_count: got %0d required 5", wr_stamp.size());
        end
        for (int k = 0; k < exp_stamp.size() && k < wr_stamp.size(); k++) begin
            vectors++;
            if (wr_stamp[k] != exp_stamp[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL midrst_write[%0d]: got t=%0d a=%h d=%h required t=%0d a=%h d=%h",
                         k, wr_stamp[k], wr_addr[k], wr_data[k], exp_stamp[k], exp_addr[k], exp_data[k]);
            end
        end
        clear_capture();
        pulse_start();
        drive_load(8, 7, 0);
        model_load();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.load_done !== 1'b1 || bus.byte_count !== 8'd8 || wr_stamp.size() != exp_stamp.size()) begin
            miscompares++;
            $display("FAIL midrst_reload: got done=%b cnt=%0d writes=%0d required 1 8 %0d",
                     bus.load_done, bus.byte_count, wr_stamp.size(), exp_stamp.size());
        end
    endtask

    task automatic test_fetch_bounds();
        logic [31:0] pcs[11];
        bit exp_oob;
        pcs[0] = 32'd0;
        pcs[1] = 32'd4;
        pcs[2] = 32'd5;
        pcs[3] = 32'd8;
        pcs[4] = 32'hFFFF_FFFE;
        pcs[5] = 32'hFFFF_FFFD;
        for (int i = 6; i < 11; i++) pcs[i] = 32'($urandom_range(0, 12));
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        clear_capture();
        pulse_start();
        drive_load(8, 7, 2);
        model_load();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            bus.if_pc = pcs[i];
            #1;
            exp_oob = (exp_state == M_DONE) && (({32'd0, pcs[i]} + 64'd3) >= 64'(exp_cnt));
            vectors++;
            if (bus.fetch_oob !== exp_oob) begin
                miscompares++;
                $display("FAIL fetch_oob pc=%h: got %b required %b", pcs[i], bus.fetch_oob, exp_oob);
            end
            @(negedge clk);
        end
        bus.start = 1'b1;
        #1;
        vectors++;
        if (bus.core_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL done_stall_before_start: got %b required 0", bus.core_stall);
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        vectors++;
        if (bus.core_stall !== 1'b1 || bus.fetch_oob !== 1'b0) begin
            miscompares++;
            $display("FAIL done_restart: got stall=%b oob=%b required 1 0", bus.core_stall, bus.fetch_oob);
        end
        apply_reset();
    endtask

    task automatic test_random_loads();
        int len;
        int last;
        logic [31:0] pc;
        bit exp_oob;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                len  = $urandom_range(41, 44);
                last = -1;
            end else begin
                last = $urandom_range(0, 43);
                len  = last + 1;
            end
            for (int i = 0; i < len; i++) img[i] = 8'($urandom);
            clear_capture();
            pulse_start();
            drive_load(len, last, 2);
            model_load();
            repeat (3) @(negedge clk);
            #1;
            vectors++;
            if (wr_stamp.size() != exp_stamp.size()) begin
                miscompares++;
                $display("FAIL rnd%0d_write_count: got %0d required %0d", it, wr_stamp.size(), exp_stamp.size());
            end
            for (int k = 0; k < exp_stamp.size() && k < wr_stamp.size(); k++) begin
                vectors++;
                if (wr_stamp[k] != exp_stamp[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_write[%0d]: got t=%0d a=%h d=%h required t=%0d a=%h d=%h",
                             it, k, wr_stamp[k], wr_addr[k], wr_data[k], exp_stamp[k], exp_addr[k], exp_data[k]);
                end
            end
            vectors++;
            if (bus.load_done !== (exp_state == M_DONE) || bus.load_err !== (exp_state == M_ERR) ||
                bus.core_stall !== (exp_state != M_DONE) || bus.byte_count !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL rnd%0d_final: got done=%b err=%b stall=%b cnt=%0d required done=%b err=%b stall=%b cnt=%0d",
                         it, bus.load_done, bus.load_err, bus.core_stall, bus.byte_count,
                         exp_state == M_DONE, exp_state == M_ERR, exp_state != M_DONE, exp_cnt);
            end
            pc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 48)) : 32'($urandom);
            bus.if_pc = pc;
            #1;
            exp_oob = (exp_state == M_DONE) && (({32'd0, pc} + 64'd3) >= 64'(exp_cnt));
            vectors++;
            if (bus.fetch_oob !== exp_oob) begin
                miscompares++;
                $display("FAIL rnd%0d_fetch_oob pc=%h: got %b required %b", it, pc, bus.fetch_oob, exp_oob);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_misaligned();
        test_overflow();
        test_reset_midload();
        test_fetch_bounds();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
